// File: rtl/div11_seq_32.sv
// ============================================================================
// Module   : div11_seq_32
// Purpose  : Sequential unsigned divide-by-11. The dividend is consumed
//            MSB-first, two bits per clock. A running remainder below 11 is
//            carried forward, and each step yields one base-4 quotient digit.
//            Valid/ready handshake on both the input and the output side.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_valid   dividend presented
//            in_ready   unit can accept a dividend (IDLE only, registered)
//            in_data    DW-bit unsigned dividend
//            out_valid  result held on out_quot/out_rem (registered)
//            out_ready  consumer accepts result
//            out_quot   floor(in_data / 11)
//            out_rem    in_data mod 11 (only with DIV11_REM_OUT_EN)
//            busy       high while in RUN or DONE
// Config   : DIV11_REM_OUT_EN - when defined, adds the out_rem port.
//            DW must be even and >= 2; the unit takes DW/2 steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div11_seq_32 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_quot,
`ifdef DIV11_REM_OUT_EN
    output logic [3:0]    out_rem,
`endif
    output logic          busy
);

    localparam int c_STEPS = DW / 2;
    localparam int c_CW    = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(c_STEPS - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_sh;
    logic [DW-1:0]   r_q;
    logic [3:0]      r_rem;
    logic [c_CW-1:0] r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    // One reduction step: w = 4*r + next two dividend bits (w <= 43).
    logic [5:0]      w_w;
    logic [1:0]      w_digit;
    logic [3:0]      w_sub;
    logic [3:0]      w_rem_next;
    logic [DW-1:0]   w_q_next;
    logic [DW-1:0]   w_sh_next;

    assign w_w = {r_rem, r_sh[DW-1 -: 2]};

    // The subtrahend 11*digit is kept modulo 16: the true remainder is
    // always 0..10, so 4-bit wrap-around arithmetic gives it exactly
    // (11 -> 11, 22 -> 6, 33 -> 1).
    always_comb begin
        w_digit = 2'd0;
        w_sub   = 4'd0;
        if (w_w >= 6'd33) begin
            w_digit = 2'd3;
            w_sub   = 4'd1;
        end else if (w_w >= 6'd22) begin
            w_digit = 2'd2;
            w_sub   = 4'd6;
        end else if (w_w >= 6'd11) begin
            w_digit = 2'd1;
            w_sub   = 4'd11;
        end
    end

    assign w_rem_next = w_w[3:0] - w_sub;

    generate
        if (DW == 2) begin : g_dw2
            assign w_q_next  = w_digit;
            assign w_sh_next = '0;
        end else begin : g_dwn
            assign w_q_next  = {r_q[DW-3:0], w_digit};
            assign w_sh_next = {r_sh[DW-3:0], 2'b00};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_q         <= '0;
            r_rem       <= 4'd0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sh       <= in_data;
                        r_q        <= '0;
                        r_rem      <= 4'd0;
                        r_cnt      <= c_CNT_LOAD;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_q   <= w_q_next;
                    r_sh  <= w_sh_next;
                    r_rem <= w_rem_next;
                    if (r_cnt == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                S_DONE: begin
                    // in_ready rises only after the result has been taken,
                    // so a new dividend is never accepted in the same cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_quot  = r_q;

`ifdef DIV11_REM_OUT_EN
    assign out_rem = (r_state == S_DONE) ? r_rem : 4'd0;
`endif

endmodule

`default_nettype wire
